share_buffer: RTL



---
 rtl/share_pkg.sv | 43 ++++
 rtl/share_fifo.sv | 50 +++++
 rtl/share_buffer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/share_pkg.sv
// Shared constants, frame layout and FSM state type for the share result queue.
package share_pkg;

    localparam int ENTRY_W = 288;   // {nonce[31:0], hash[255:0]}
    localparam int FRAME_W = 512;

    localparam logic [63:0] FRAME_MAGIC = 64'hdead432987beefaa;
    localparam logic [7:0]  FRAME_SEP   = 8'haa;

    // Bit offsets of the fields inside the 512-bit result frame
    localparam int HASH_LSB  = 0;
    localparam int SEP0_LSB  = 256;
    localparam int NONCE_LSB = 264;
    localparam int SEP1_LSB  = 296;
    localparam int SEQ_LSB   = 304;
    localparam int MAGIC_LSB = 448;

    // Cycles with tx_ready still high after a request before the frame is assumed taken
    localparam int WAIT_BUSY_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    // Assemble one result frame; unused bits [447:320] stay zero
    function automatic logic [FRAME_W-1:0] build_frame(input logic [255:0] hash,
                                                       input logic [31:0]  nonce,
                                                       input logic [15:0]  seq);
        logic [FRAME_W-1:0] f;
        f = '0;
        f[HASH_LSB  +: 256] = hash;
        f[SEP0_LSB  +: 8]   = FRAME_SEP;
        f[NONCE_LSB +: 32]  = nonce;
        f[SEP1_LSB  +: 8]   = FRAME_SEP;
        f[SEQ_LSB   +: 16]  = seq;
        f[MAGIC_LSB +: 64]  = FRAME_MAGIC;
        return f;
    endfunction

endpackage

// File: rtl/share_fifo.sv
// Circular FIFO with wrap-bit pointers; push while full succeeds only alongside a pop.
module share_fifo #(
    parameter  int WIDTH = 288,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign level_o = wptr_q - rptr_q;
    assign full_o  = (level_o == (AW+1)'(DEPTH));
    assign empty_o = (level_o == '0);
    assign do_pop  = pop_i && !empty_o;
    // When full, the slot being written is the head that is leaving this same edge
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    // Storage write; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

    // Pointer update; the extra MSB distinguishes full from empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/share_buffer.sv
// Captures the winning finisher hit each cycle, queues it, and hands formatted
// 512-bit result frames to the UART transmitter with a req/ready handshake.
// Handshake: tx_req is a single-cycle pulse with tx_data valid in that cycle;
// the transmitter signals it took the frame by dropping tx_ready, and signals
// completion by raising it again. If tx_ready never drops within
// WAIT_BUSY_MAX cycles the frame is considered delivered.
module share_buffer
    import share_pkg::*;
#(
    parameter  int NUM_COPIES = 3,
    parameter  int DEPTH      = 4,
    parameter  int DROP_W     = 16,
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_COPIES-1:0]     hit_valid,
    input  logic [NUM_COPIES*256-1:0] hit_hash,
    input  logic [NUM_COPIES*32-1:0]  hit_nonce,
    input  logic                      tx_ready,
    output logic                      tx_req,
    output logic [FRAME_W-1:0]        tx_data,
    output logic [LVL_W-1:0]          level,
    output logic [DROP_W-1:0]         dropped_count,
    output state_t                    dbg_state
);

    localparam logic [1:0] BUSY_LAST = 2'(WAIT_BUSY_MAX - 1);

    // Capture stage
    logic               win_found;
    logic [ENTRY_W-1:0] win_entry;
    logic [DROP_W:0]    hit_cnt;
    logic [DROP_W:0]    extra_drops;
    logic               cap_valid_q;
    logic [ENTRY_W-1:0] cap_entry_q;

    // FIFO interface
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;

    // Drop accounting
    logic               full_drop;
    logic [DROP_W:0]    drop_inc;
    logic [DROP_W:0]    drop_sum;
    logic [DROP_W-1:0]  dropped_d;
    logic [DROP_W-1:0]  dropped_q;

    // Transmit FSM
    state_t             state_q;
    logic               tx_req_q;
    logic [FRAME_W-1:0] tx_data_q;
    logic [15:0]        seq_q;
    logic [1:0]         busy_cnt_q;

    // Pick the highest-index copy reporting a hit and count all reporting copies
    always_comb begin
        win_found = 1'b0;
        win_entry = '0;
        hit_cnt   = '0;
        for (int i = 0; i < NUM_COPIES; i++) begin
            if (hit_valid[i]) begin
                win_found = 1'b1;
                win_entry = {hit_nonce[32*i +: 32], hit_hash[256*i +: 256]};
                hit_cnt   = hit_cnt + (DROP_W+1)'(1);
            end
        end
    end

    assign extra_drops = win_found ? (hit_cnt - (DROP_W+1)'(1)) : '0;

    // Register the winner so the FIFO push happens one edge after sampling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_valid_q <= 1'b0;
            cap_entry_q <= '0;
        end else begin
            cap_valid_q <= win_found;
            cap_entry_q <= win_entry;
        end
    end

    assign fifo_pop  = (state_q == ST_SEND);
    assign fifo_push = cap_valid_q;
    assign full_drop = cap_valid_q && fifo_full && !fifo_pop;

    share_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (cap_entry_q),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    // Saturating add of losing copies plus a winner rejected by a full queue
    assign drop_inc  = extra_drops + {{DROP_W{1'b0}}, full_drop};
    assign drop_sum  = {1'b0, dropped_q} + drop_inc;
    assign dropped_d = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];

    // Dropped-share counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropped_q <= '0;
        end else begin
            dropped_q <= dropped_d;
        end
    end

    // Transmit FSM: frame is loaded on entry to SEND, head popped on exit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_req_q   <= 1'b0;
            tx_data_q  <= '0;
            seq_q      <= '0;
            busy_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty && tx_ready) begin
                        state_q   <= ST_SEND;
                        tx_req_q  <= 1'b1;
                        tx_data_q <= build_frame(fifo_head[255:0], fifo_head[287:256], seq_q);
                    end
                end
                ST_SEND: begin
                    tx_req_q   <= 1'b0;
                    seq_q      <= seq_q + 16'd1;
                    busy_cnt_q <= '0;
                    state_q    <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!tx_ready) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (busy_cnt_q == BUSY_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        busy_cnt_q <= busy_cnt_q + 2'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (tx_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_req        = tx_req_q;
    assign tx_data       = tx_data_q;
    assign dropped_count = dropped_q;
    assign dbg_state     = state_q;

endmodule
